// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed 7-segment scanner.
// Scans N_DIGITS active-low patterns onto one shared segment bus and strobes
// one active-low anode per slot. Each slot starts with a blanking gap so the
// previous digit's segments do not ghost onto the next one. Patterns are
// snapshotted once per frame, so a frame never shows a mix of old and new data.
// Optional feature: define SSEG_BRIGHTNESS_EN to add brightness_i, which
// shortens the lit part of every slot (PWM dimming).
module sseg_scan_driver #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [7*N_DIGITS-1:0]         sseg_i,
    input  logic [N_DIGITS-1:0]           dp_i,
`ifdef SSEG_BRIGHTNESS_EN
    input  logic [3:0]                    brightness_i,
`endif
    output logic [6:0]                    sseg_o,
    output logic                          dp_o,
    output logic [N_DIGITS-1:0]           an_o,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx_o,
    output logic                          frame_o
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(N_DIGITS);

    localparam logic [CW-1:0] LAST_EDGE  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [6:0]           sh_seg [N_DIGITS];
    logic [N_DIGITS-1:0]  sh_dp;

    logic [CW-1:0]   edge_n;
    logic [IW-1:0]   idx_n;
    logic            frame_start;
    logic            snap;
    logic            lit;

`ifdef SSEG_BRIGHTNESS_EN
    localparam logic [31:0] DRIVE_LEN = 32'(REFRESH_DIV - BLANK_CYCLES);
    logic [3:0]  sh_bright;
    logic [31:0] on_len;

    // Lit length of the drive window: floor((b+1)*D/16), never below one cycle
    always_comb begin
        on_len = ((32'(sh_bright) + 32'd1) * DRIVE_LEN) >> 4;
        if (on_len == '0) begin
            on_len = 32'd1;
        end
        lit = (32'(edge_n) < (32'(BLANK_CYCLES) + on_len));
    end
`else
    assign lit = 1'b1;
`endif

    // Next slot edge, next digit and frame boundary while scanning
    always_comb begin
        edge_n = (cnt == LAST_EDGE) ? '0 : cnt + 1'b1;
        idx_n  = digit_idx_o;
        if (edge_n == '0) begin
            idx_n = (digit_idx_o == LAST_DIGIT) ? '0 : digit_idx_o + 1'b1;
        end
        frame_start = (edge_n == '0) && (idx_n == '0);
        snap        = en_i && ((state == IDLE) || frame_start);
    end

    // Frame snapshot of the patterns, taken on edge 0 of digit 0's slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                sh_seg[k] <= '1;
            end
            sh_dp <= '0;
`ifdef SSEG_BRIGHTNESS_EN
            sh_bright <= '1;
`endif
        end else if (snap) begin
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                sh_seg[k] <= sseg_i[7*k +: 7];
            end
            sh_dp <= dp_i;
`ifdef SSEG_BRIGHTNESS_EN
            sh_bright <= brightness_i;
`endif
        end
    end

    // Scan FSM with registered pin outputs; the anode vector is decoded from a
    // single index, so at most one anode can ever be low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_idx_o <= '0;
            frame_o     <= 1'b0;
            an_o        <= '1;
            sseg_o      <= 7'h7F;
            dp_o        <= 1'b1;
        end else if (!en_i) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_idx_o <= '0;
            frame_o     <= 1'b0;
            an_o        <= '1;
            sseg_o      <= 7'h7F;
            dp_o        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state       <= BLANK;
                    cnt         <= '0;
                    digit_idx_o <= '0;
                    frame_o     <= 1'b1;
                    an_o        <= '1;
                    sseg_o      <= 7'h7F;
                    dp_o        <= 1'b1;
                end
                default: begin
                    cnt         <= edge_n;
                    digit_idx_o <= idx_n;
                    frame_o     <= frame_start;
                    if (edge_n < BLANK_END) begin
                        state  <= BLANK;
                        an_o   <= '1;
                        sseg_o <= 7'h7F;
                        dp_o   <= 1'b1;
                    end else if (lit) begin
                        state  <= DRIVE;
                        an_o   <= ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_n);
                        sseg_o <= sh_seg[idx_n];
                        dp_o   <= ~sh_dp[idx_n];
                    end else begin
                        state  <= DRIVE;
                        an_o   <= '1;
                        sseg_o <= 7'h7F;
                        dp_o   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
